// File: rtl/ram8_copy.sv
// rtl/ram8_copy.sv - byte-wide RAM block copy engine with optional fill mode
//
// Moves len bytes from src to dst over a single-port synchronous RAM,
// one READ cycle then one WRITE cycle per byte, addresses ascending and
// wrapping modulo 2^ADDR_W.
//
// Build option: RAM8_COPY_FILL_EN enables fill mode. When it is set, fill=1
// at start writes fill_val to len bytes at dst, one byte per cycle.
// Without it, fill and fill_val are ignored and every request is a copy.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   start                request, accepted only while idle
//   fill                 mode at start: 0 copy, 1 fill
//   src, dst             first source / destination byte address
//   len                  byte count, 0..2^ADDR_W
//   fill_val             fill byte
//   busy                 high while reading or writing
//   done                 one-cycle completion pulse
//   mem_en, mem_wr       RAM enable / write strobe
//   mem_addr, mem_din    RAM address / write data
//   mem_dout             RAM read data, valid the cycle after a read
module ram8_copy #(
    parameter int ADDR_W = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              fill,
    input  logic [ADDR_W-1:0] src,
    input  logic [ADDR_W-1:0] dst,
    input  logic [ADDR_W:0]   len,
    input  logic [7:0]        fill_val,
    output logic              busy,
    output logic              done,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_din,
    input  logic [7:0]        mem_dout
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        DONE
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [ADDR_W-1:0] src_q;
    logic [ADDR_W-1:0] dst_q;
    logic [ADDR_W:0]   cnt_q;
    logic              last_byte;
    logic              fill_req;
    logic              fill_q;

`ifdef RAM8_COPY_FILL_EN
    logic [7:0] val_q;

    assign fill_req = fill;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_q <= 1'b0;
            val_q  <= 8'd0;
        end else if (state == IDLE && start) begin
            fill_q <= fill;
            val_q  <= fill_val;
        end
    end
`else
    logic unused_fill;

    assign fill_req    = 1'b0;
    assign fill_q      = 1'b0;
    assign unused_fill = ^{fill, fill_val};
`endif

    // The count still holds the pre-decrement value during WRITE, so a
    // count of one means this write is the final byte.
    assign last_byte = (cnt_q == (ADDR_W+1)'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            src_q <= '0;
            dst_q <= '0;
            cnt_q <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (start) begin
                        src_q <= src;
                        dst_q <= dst;
                        cnt_q <= len;
                    end
                end
                WRITE: begin
                    src_q <= src_q + ADDR_W'(1);
                    dst_q <= dst_q + ADDR_W'(1);
                    cnt_q <= cnt_q - (ADDR_W+1)'(1);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        mem_en   = 1'b0;
        mem_wr   = 1'b0;
        mem_addr = '0;
        mem_din  = 8'd0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (len == '0)
                        state_nx = DONE;
                    else if (fill_req)
                        state_nx = WRITE;
                    else
                        state_nx = READ;
                end
            end
            READ: begin
                busy     = 1'b1;
                mem_en   = 1'b1;
                mem_addr = src_q;
                state_nx = WRITE;
            end
            WRITE: begin
                busy     = 1'b1;
                mem_en   = 1'b1;
                mem_wr   = 1'b1;
                mem_addr = dst_q;
`ifdef RAM8_COPY_FILL_EN
                mem_din  = fill_q ? val_q : mem_dout;
`else
                mem_din  = mem_dout;
`endif
                if (last_byte)
                    state_nx = DONE;
                else if (fill_q)
                    state_nx = WRITE;
                else
                    state_nx = READ;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_ram8_copy.sv
// tb/tb_ram8_copy.sv - self-checking bench for ram8_copy
module tb_ram8_copy;

    localparam int AW    = 15;
    localparam int DEPTH = 1 << AW;
`ifdef RAM8_COPY_FILL_EN
    localparam bit FILL_EN = 1'b1;
`else
    localparam bit FILL_EN = 1'b0;
`endif

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          fill;
    logic [AW-1:0] src;
    logic [AW-1:0] dst;
    logic [AW:0]   len;
    logic [7:0]    fill_val;
    logic          busy;
    logic          done;
    logic          mem_en;
    logic          mem_wr;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_din;
    logic [7:0]    mem_dout;

    logic [7:0] ram     [0:DEPTH-1];
    logic [7:0] ref_mem [0:DEPTH-1];

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [7:0]    data;
    } op_t;

    typedef struct {
        logic          f;
        logic [AW-1:0] s;
        logic [AW-1:0] d;
        logic [AW:0]   n;
        logic [7:0]    fv;
        bit            mid;
        int            exp_done;
    } vec_t;

    ram8_copy #(.ADDR_W(AW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .fill     (fill),
        .src      (src),
        .dst      (dst),
        .len      (len),
        .fill_val (fill_val),
        .busy     (busy),
        .done     (done),
        .mem_en   (mem_en),
        .mem_wr   (mem_wr),
        .mem_addr (mem_addr),
        .mem_din  (mem_din),
        .mem_dout (mem_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_wr)
                ram[mem_addr] <= mem_din;
            else
                mem_dout <= ram[mem_addr];
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic check_mem(input string name);
        int bad;
        bad = 0;
        for (int a = 0; a < DEPTH; a++)
            if (ram[a] !== ref_mem[a]) bad++;
        chk(name, 64'(bad), 64'd0);
    endtask

    // Reference: the transfer is an ordered list of RAM operations derived
    // directly from the byte-by-byte copy/fill rule; the DUT must emit
    // exactly this list, one operation per cycle, then a single done cycle.
    task automatic run_xfer(input logic f, input logic [AW-1:0] s, input logic [AW-1:0] d,
                            input logic [AW:0] n, input logic [7:0] fv, input bit mid,
                            output int done_cyc);
        op_t           q[$];
        op_t           op;
        bit            fm;
        int            lim;
        logic [AW-1:0] sa;
        logic [AW-1:0] da;
        fm = f && FILL_EN;
        for (int i = 0; i < int'(n); i++) begin
            sa = s + AW'(i);
            da = d + AW'(i);
            if (fm) begin
                op.wr = 1'b1; op.addr = da; op.data = fv;
                q.push_back(op);
            end else begin
                op.wr = 1'b0; op.addr = sa; op.data = 8'd0;
                q.push_back(op);
                op.wr = 1'b1; op.addr = da; op.data = ref_mem[sa];
                q.push_back(op);
            end
            ref_mem[da] = op.data;
        end
        start = 1'b1; fill = f; src = s; dst = d; len = n; fill_val = fv;
        @(negedge clk);
        start    = 1'b0;
        fill     = ~f;
        src      = AW'($urandom);
        dst      = AW'($urandom);
        len      = (AW+1)'($urandom);
        fill_val = ~fv;
        done_cyc = -1;
        lim      = 2 * int'(n) + 4;
        for (int c = 1; c <= lim; c++) begin
            if (q.size() > 0) begin
                op = q.pop_front();
                chk("xfer_ctl", {busy, done, mem_en, mem_wr, mem_addr},
                    {1'b1, 1'b0, 1'b1, op.wr, op.addr});
                if (op.wr) chk("xfer_din", mem_din, op.data);
            end else begin
                chk("xfer_done", {busy, done, mem_en, mem_wr, mem_addr, mem_din},
                    {2'b01, 2'b00, 15'd0, 8'd0});
                if (done) done_cyc = c;
                break;
            end
            start = mid && (c == 3);
            @(negedge clk);
        end
        start = 1'b0;
        @(negedge clk);
        chk("idle_after", {busy, done, mem_en, mem_wr}, 4'b0000);
    endtask

    vec_t tbl [6];

    initial begin
        #3_000_000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int dc;
        logic          rf;
        logic [AW:0]   rn;
        bit            rmid;
        int            rexp;

        for (int a = 0; a < DEPTH; a++) begin
            ram[a]     = 8'($urandom);
            ref_mem[a] = ram[a];
        end
        for (int i = 0; i < 4; i++) begin
            ram[16 + i]     = 8'(8'h11 * (i + 1));
            ref_mem[16 + i] = ram[16 + i];
        end

        //          f     src       dst       len  fv     mid  done
        tbl[0] = '{1'b0, 15'h0010, 15'h0100, 16'd4, 8'h00, 1'b0, 9};
        tbl[1] = '{1'b0, 15'h0020, 15'h0400, 16'd0, 8'h00, 1'b0, 1};
        tbl[2] = '{1'b0, 15'h7FFE, 15'h0200, 16'd3, 8'h00, 1'b0, 7};
        tbl[3] = '{1'b1, 15'h0040, 15'h0300, 16'd3, 8'hA5, 1'b0, FILL_EN ? 4 : 7};
        tbl[4] = '{1'b0, 15'h0010, 15'h0011, 16'd3, 8'h00, 1'b0, 7};
        tbl[5] = '{1'b0, 15'h0500, 15'h0600, 16'd4, 8'h00, 1'b1, 9};

        rst_n = 1'b0; start = 1'b0; fill = 1'b0; src = '0; dst = '0;
        len = '0; fill_val = 8'd0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {busy, done, mem_en, mem_wr, mem_addr, mem_din}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_outputs", {busy, done, mem_en, mem_wr, mem_addr, mem_din}, 64'd0);

        for (int t = 0; t < 6; t++) begin
            run_xfer(tbl[t].f, tbl[t].s, tbl[t].d, tbl[t].n, tbl[t].fv, tbl[t].mid, dc);
            chk($sformatf("done_cycle_%0d", t), 64'(dc), 64'(tbl[t].exp_done));
            check_mem($sformatf("mem_vec_%0d", t));
        end

        // Reset during the second WRITE of a 4-byte copy.
        start = 1'b1; fill = 1'b0; src = 15'h0700; dst = 15'h0710; len = 16'd4;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_pre", {busy, mem_en, mem_wr, mem_addr}, {3'b111, 15'h0711});
        #1 rst_n = 1'b0;
        #1 chk("rst_async", {busy, done, mem_en, mem_wr, mem_addr, mem_din}, 64'd0);
        ref_mem[15'h0710] = ref_mem[15'h0700];
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk("rst_quiet", {busy, done, mem_en, mem_wr}, 4'b0000);
        end
        check_mem("mem_rst");

        for (int r = 0; r < 25; r++) begin
            rf   = 1'($urandom);
            rn   = (AW+1)'($urandom_range(0, 24));
            rmid = 1'($urandom);
            if (rn == 0)
                rexp = 1;
            else if (rf && FILL_EN)
                rexp = int'(rn) + 1;
            else
                rexp = 2 * int'(rn) + 1;
            run_xfer(rf, AW'($urandom), AW'($urandom), rn, 8'($urandom), rmid, dc);
            chk("rand_done_cycle", 64'(dc), 64'(rexp));
        end
        check_mem("mem_rand");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
